// File: rtl/my_nios1_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports, byte-lane writes,
// power-on clear engine, selectable read latency and out-of-range protection.
module my_nios1_onchip_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 5120,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [NB-1:0][7:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             init_done_q, init_done_d;
  logic             clr_we;
  logic             waitreq;

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic                  cs    [2];
  logic                  rd    [2];
  logic                  wr    [2];

  logic                  rd_acc  [2];
  logic                  wr_en   [2];
  logic                  in_rng  [2];
  logic [IDX_W-1:0]      idx     [2];
  logic [DATA_WIDTH-1:0] rd_word [2];

  logic [DATA_WIDTH-1:0] rdata_p1_q [2];
  logic                  vld_p1_q   [2];
  logic [DATA_WIDTH-1:0] rdata_out  [2];
  logic                  vld_out    [2];

  assign addr[0]  = s1_address;    assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable; assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;  assign wdata[1] = s2_writedata;
  assign cs[0]    = s1_chipselect; assign cs[1]    = s2_chipselect;
  assign rd[0]    = s1_read;       assign rd[1]    = s2_read;
  assign wr[0]    = s1_write;      assign wr[1]    = s2_write;

  // init_done_q doubles as the "ready" flag so waitrequest stays high during reset
  assign waitreq        = ~init_done_q | ~clken | reset_req;
  assign s1_waitrequest = waitreq;
  assign s2_waitrequest = waitreq;
  assign init_done      = init_done_q;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p]  = ({1'b0, addr[p]} < DEPTH_L);
      idx[p]     = addr[p][IDX_W-1:0];
      rd_acc[p]  = cs[p] & rd[p] & ~wr[p] & ~waitreq;
      wr_en[p]   = cs[p] & wr[p] & ~waitreq & in_rng[p];
      rd_word[p] = in_rng[p] ? mem[idx[p]] : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d     = READY;
          clr_cnt_d   = '0;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY:   init_done_d = 1'b1;
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage: s1 lanes are assigned last so they override s2 on a same-address collision
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_cnt_q] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (wr_en[1] && be[1][b]) mem[idx[1]][b] <= wdata[1][b*8 +: 8];
      if (wr_en[0] && be[0][b]) mem[idx[0]][b] <= wdata[0][b*8 +: 8];
    end
  end

  // Stage p1: array read at the accept edge (sees pre-write contents)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        vld_p1_q[p]   <= 1'b0;
        rdata_p1_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_p1_q[p] <= rd_acc[p];
        if (rd_acc[p]) rdata_p1_q[p] <= rd_word[p];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rdata_p2_q [2];
      logic                  vld_p2_q   [2];
      // Stage p2: optional output register
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int p = 0; p < 2; p++) begin
            vld_p2_q[p]   <= 1'b0;
            rdata_p2_q[p] <= '0;
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            vld_p2_q[p] <= vld_p1_q[p];
            if (vld_p1_q[p]) rdata_p2_q[p] <= rdata_p1_q[p];
          end
        end
      end
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          rdata_out[p] = rdata_p2_q[p];
          vld_out[p]   = vld_p2_q[p];
        end
      end
    end else begin : g_lat1
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          rdata_out[p] = rdata_p1_q[p];
          vld_out[p]   = vld_p1_q[p];
        end
      end
    end
  endgenerate

  assign s1_readdata      = rdata_out[0];
  assign s1_readdatavalid = vld_out[0];
  assign s2_readdata      = rdata_out[1];
  assign s2_readdatavalid = vld_out[1];

endmodule

// File: tb/tb_my_nios1_onchip_memory_dp.sv
// Directed bench: DUT A (DEPTH=16, latency 2, clear) and DUT B (DEPTH=5120, latency 1, no clear).
module tb_my_nios1_onchip_memory_dp;

  logic clk = 1'b0;
  logic reset_n, clken, reset_req;
  // port index: 0 = A.s1, 1 = A.s2, 2 = B.s1, 3 = B.s2
  logic [12:0] addr [4];
  logic [3:0]  be   [4];
  logic        cs   [4];
  logic        rd   [4];
  logic        wr   [4];
  logic [31:0] wd   [4];
  logic [31:0] rdat [4];
  logic        vld  [4];
  logic        wreq [4];
  logic        ido  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  my_nios1_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(16),
                              .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]),
    .s1_read(rd[0]), .s1_write(wr[0]), .s1_writedata(wd[0]),
    .s1_readdata(rdat[0]), .s1_readdatavalid(vld[0]), .s1_waitrequest(wreq[0]),
    .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]),
    .s2_read(rd[1]), .s2_write(wr[1]), .s2_writedata(wd[1]),
    .s2_readdata(rdat[1]), .s2_readdatavalid(vld[1]), .s2_waitrequest(wreq[1]),
    .init_done(ido[0]));

  my_nios1_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .DEPTH(5120),
                              .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[2]), .s1_byteenable(be[2]), .s1_chipselect(cs[2]),
    .s1_read(rd[2]), .s1_write(wr[2]), .s1_writedata(wd[2]),
    .s1_readdata(rdat[2]), .s1_readdatavalid(vld[2]), .s1_waitrequest(wreq[2]),
    .s2_address(addr[3]), .s2_byteenable(be[3]), .s2_chipselect(cs[3]),
    .s2_read(rd[3]), .s2_write(wr[3]), .s2_writedata(wd[3]),
    .s2_readdata(rdat[3]), .s2_readdatavalid(vld[3]), .s2_waitrequest(wreq[3]),
    .init_done(ido[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int p, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + ((p < 2) ? 2 : 1);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop(input int p, output bit ok, output exp_t e);
    ok = 1'b0;
    e.data = '0;
    e.due  = 0;
    case (p)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Scoreboard: every readdatavalid strobe must match the oldest expectation
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (vld[p] === 1'b1) begin
        bit   ok;
        exp_t e;
        pop(p, ok, e);
        if (!ok) chk($sformatf("p%0d_unexpected_valid", p), {31'b0, vld[p]}, 32'd0);
        else begin
          chk($sformatf("p%0d_rdata", p), rdat[p], e.data);
          chk($sformatf("p%0d_latency_cycle", p), cyc, e.due);
        end
      end
    end
  end

  task automatic set_req(input int p, input bit r, input bit w, input logic [12:0] a,
                         input logic [3:0] b, input logic [31:0] d, input logic [31:0] e);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
    if (r && !w) push(p, e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic wait_init();
    int n = 0;
    while (ido[0] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("init_done_timeout", {31'b0, ido[0]}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    for (int p = 0; p < 4; p++) begin
      addr[p] = '0; be[p] = '0; cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; wd[p] = '0;
    end
    step(); step();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_rdata_p%0d", p), rdat[p], 32'd0);
      chk($sformatf("rst_valid_p%0d", p), {31'b0, vld[p]}, 32'd0);
      chk($sformatf("rst_waitreq_p%0d", p), {31'b0, wreq[p]}, 32'd1);
    end
    chk("rst_init_done_a", {31'b0, ido[0]}, 32'd0);
    chk("rst_init_done_b", {31'b0, ido[1]}, 32'd0);
    reset_n = 1'b1;
    wait_init();

    // Preload, then pulse reset (once mid-clear) and verify the full clear
    set_req(0, 0, 1, 13'd5, 4'hF, 32'hFFFF_FFFF, 0); step();
    set_req(1, 1, 0, 13'd5, 4'h0, 0, 32'hFFFF_FFFF); step();
    drain();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    repeat (6) step();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("clear_waitreq_e%0d", i), {31'b0, wreq[0]}, 32'd1);
      chk($sformatf("clear_init_done_e%0d", i), {31'b0, ido[0]}, 32'd0);
      if (i == 1) chk("b_init_before_edge1", {31'b0, ido[1]}, 32'd0);
      if (i == 2) chk("b_init_after_edge1", {31'b0, ido[1]}, 32'd1);
      step();
    end
    chk("clear_done_init", {31'b0, ido[0]}, 32'd1);
    chk("clear_done_waitreq", {31'b0, wreq[1]}, 32'd0);
    set_req(0, 1, 0, 13'd5, 4'h0, 0, 32'h0); step();
    drain();

    // Byte-lane writes, cross-port read at latency 2
    set_req(0, 0, 1, 13'd3, 4'b1111, 32'h1122_3344, 0); step();
    set_req(0, 0, 1, 13'd3, 4'b0101, 32'hAABB_CCDD, 0); step();
    set_req(1, 1, 0, 13'd3, 4'h0, 0, 32'h11BB_33DD); step();
    drain();

    // Same-address write collision
    set_req(0, 0, 1, 13'd7, 4'b0001, 32'h0000_00AA, 0);
    set_req(1, 0, 1, 13'd7, 4'b1111, 32'hBBBB_BBBB, 0); step();
    set_req(0, 1, 0, 13'd7, 4'h0, 0, 32'hBBBB_BBAA); step();
    drain();

    // Read-before-write across ports
    set_req(0, 0, 1, 13'd9, 4'hF, 32'h1, 0); step();
    set_req(0, 0, 1, 13'd9, 4'hF, 32'h2, 0);
    set_req(1, 1, 0, 13'd9, 4'h0, 0, 32'h1); step();
    set_req(1, 1, 0, 13'd9, 4'h0, 0, 32'h2); step();
    drain();

    // Back-to-back reads, then readdata must hold
    set_req(0, 1, 0, 13'd3, 4'h0, 0, 32'h11BB_33DD); step();
    set_req(0, 1, 0, 13'd7, 4'h0, 0, 32'hBBBB_BBAA); step();
    set_req(0, 1, 0, 13'd9, 4'h0, 0, 32'h2); step();
    drain();
    chk("hold_rdata", rdat[0], 32'h2);
    chk("hold_valid", {31'b0, vld[0]}, 32'd0);

    // read+write together is a write with no readdatavalid
    set_req(1, 1, 1, 13'd10, 4'hF, 32'h55, 0); step();
    set_req(0, 1, 0, 13'd10, 4'h0, 0, 32'h55); step();
    drain();

    // Out of range on A (DEPTH=16): no aliasing into address 0
    set_req(0, 0, 1, 13'd16, 4'hF, 32'hCAFE, 0); step();
    set_req(0, 1, 0, 13'd16, 4'h0, 0, 32'h0); step();
    set_req(1, 1, 0, 13'd0, 4'h0, 0, 32'h0); step();
    drain();

    // Out of range on B (DEPTH=5120), latency 1
    set_req(2, 0, 1, 13'd0, 4'hF, 32'h1234_5678, 0); step();
    set_req(2, 0, 1, 13'd5120, 4'hF, 32'hDEAD, 0); step();
    set_req(2, 1, 0, 13'd5120, 4'h0, 0, 32'h0); step();
    set_req(3, 1, 0, 13'd0, 4'h0, 0, 32'h1234_5678); step();
    drain();

    // Stall: in-flight read completes while clken is low; new requests blocked
    set_req(0, 1, 0, 13'd3, 4'h0, 0, 32'h11BB_33DD); step();
    clken = 1'b0;
    #1;
    chk("stall_waitreq_a1", {31'b0, wreq[0]}, 32'd1);
    chk("stall_waitreq_a2", {31'b0, wreq[1]}, 32'd1);
    chk("stall_waitreq_b1", {31'b0, wreq[2]}, 32'd1);
    cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 13'd7;
    step(); step();
    clken = 1'b1;
    drain();
    reset_req = 1'b1;
    #1;
    chk("reset_req_waitreq", {31'b0, wreq[3]}, 32'd1);
    step();
    reset_req = 1'b0;
    #1;
    chk("reset_req_release", {31'b0, wreq[3]}, 32'd0);
    step();

    // Flush: reset with one read in flight
    set_req(0, 1, 0, 13'd9, 4'h0, 0, 32'h2); step();
    reset_n = 1'b0;
    q0.delete();
    #1;
    chk("flush_valid", {31'b0, vld[0]}, 32'd0);
    chk("flush_rdata", rdat[0], 32'd0);
    chk("flush_waitreq", {31'b0, wreq[0]}, 32'd1);
    chk("flush_init_done", {31'b0, ido[0]}, 32'd0);
    step(); step();
    chk("flush_valid_later", {31'b0, vld[0]}, 32'd0);
    reset_n = 1'b1;
    wait_init();
    drain();

    chk("scoreboard_empty", q0.size() + q1.size() + q2.size() + q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
